// File: rtl/instruction_queue_if.sv
// Bus-side signal bundle of the instruction queue: push/pop/flush strobes,
// the incoming instruction word and the head/status outputs.
interface instruction_queue_if #(
  parameter int OP_W  = 4,
  parameter int ARG_W = 4,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [OP_W+ARG_W-1:0] IR_in;
  logic                  nLi;
  logic                  nAdv;
  logic                  nFlush;
  logic                  nEi;
  logic [ARG_W-1:0]      IR_W;
  logic [OP_W-1:0]       I_sequencer;
  logic [CNT_W-1:0]      count;
  logic                  empty;
  logic                  full;
  logic                  ovf;
  logic                  unf;

  modport master (
    output IR_in, nLi, nAdv, nFlush, nEi,
    input  IR_W, I_sequencer, count, empty, full, ovf, unf
  );

  modport slave (
    input  IR_in, nLi, nAdv, nFlush, nEi,
    output IR_W, I_sequencer, count, empty, full, ovf, unf
  );
endinterface

// File: rtl/instruction_queue.sv
// Circular instruction queue feeding the sequencer: the head opcode and operand
// are presented combinationally, with sticky overflow/underflow flags.
module instruction_queue #(
  parameter int              OP_W   = 4,
  parameter int              ARG_W  = 4,
  parameter int              DEPTH  = 4,
  parameter logic [OP_W-1:0] NOP_OP = {OP_W{1'b0}}
) (
  input logic                 clk,
  input logic                 clr,
  instruction_queue_if.slave  bus
);
  localparam int W     = OP_W + ARG_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_en_s;
  logic             push_s, pop_s, empty_s, full_s;
  logic [W-1:0]     head_word_s;
  logic [ARG_W-1:0] operand_s;

  assign push_s  = ~bus.nLi;
  assign pop_s   = ~bus.nAdv;
  assign empty_s = (count_q == CNT_W'(0));
  assign full_s  = (count_q == CNT_W'(DEPTH));

  // Next-state decode: flush dominates, then the push/pop combination.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en_s = 1'b0;
    if (!bus.nFlush) begin
      head_d  = {PTR_W{1'b0}};
      tail_d  = {PTR_W{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b11: begin
          wr_en_s = 1'b1;
          tail_d  = tail_q + PTR_W'(1);
          if (empty_s) begin
            // Nothing to retire yet: the pop is an underflow, the push still lands.
            count_d = count_q + CNT_W'(1);
            unf_d   = 1'b1;
          end else begin
            head_d  = head_q + PTR_W'(1);
          end
        end
        2'b10: begin
          if (full_s) begin
            ovf_d = 1'b1;
          end else begin
            wr_en_s = 1'b1;
            tail_d  = tail_q + PTR_W'(1);
            count_d = count_q + CNT_W'(1);
          end
        end
        2'b01: begin
          if (empty_s) begin
            unf_d = 1'b1;
          end else begin
            head_d  = head_q + PTR_W'(1);
            count_d = count_q - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Pointer, occupancy and sticky flag registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage array; contents are only ever read through a valid head.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[tail_q] <= bus.IR_in;
    end
  end

  assign head_word_s = mem_q[head_q];
  assign operand_s   = empty_s ? {ARG_W{1'b0}} : head_word_s[ARG_W-1:0];

  assign bus.I_sequencer = empty_s ? NOP_OP : head_word_s[W-1:ARG_W];
  assign bus.IR_W        = bus.nEi ? {ARG_W{1'bz}} : operand_s;
  assign bus.count       = count_q;
  assign bus.empty       = empty_s;
  assign bus.full        = full_s;
  assign bus.ovf         = ovf_q;
  assign bus.unf         = unf_q;
endmodule

// File: doc/instruction_queue.md
INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

Interface
REQ-001 Parameter OP_W, default 4: opcode field width (upper bits of the instruction word).
REQ-002 Parameter ARG_W, default 4: operand/address field width (lower bits of the instruction word).
REQ-003 Parameter DEPTH, default 4: number of instruction entries; power of two, at least 2.
REQ-004 Parameter NOP_OP, default 4'b0000 (OP_W bits): opcode presented to the sequencer while the queue is empty.
REQ-005 clk  input  1  sole clock; all state changes on the rising edge.
REQ-006 clr  input  1  reset; asynchronous, active-high.
REQ-007 IR_in  input  OP_W+ARG_W  instruction word from the bus; opcode = IR_in[OP_W+ARG_W-1:ARG_W].
REQ-008 nLi  input  1  active-low push: enqueue IR_in at the tail.
REQ-009 nAdv  input  1  active-low pop: retire the head entry.
REQ-010 nFlush  input  1  active-low synchronous flush, e.g. on a taken jump.
REQ-011 nEi  input  1  active-low operand output enable.
REQ-012 IR_W  output  ARG_W  head operand when nEi=0; high-impedance when nEi=1.
REQ-013 I_sequencer  output  OP_W  head opcode; NOP_OP when empty.
REQ-014 count  output  clog2(DEPTH+1)  number of valid entries, 0..DEPTH.
REQ-015 empty / full  output  1 each  count==0 / count==DEPTH.
REQ-016 ovf / unf  output  1 each  sticky overflow / underflow flags.

Function
REQ-017 Storage shall be a circular buffer of DEPTH words with head and tail pointers that wrap modulo DEPTH.
REQ-018 Per-edge priority shall be: nFlush, then push/pop.
REQ-019 nFlush=0 shall set count=0 and head=tail=0, and shall ignore nLi and nAdv that cycle; ovf and unf shall be preserved.
REQ-020 Push only, not full: write IR_in at the tail, advance the tail, increment count.
REQ-021 Pop only, not empty: advance the head, decrement count.
REQ-022 Push and pop together, neither empty nor full: do both; count unchanged.
REQ-023 Push and pop together while full: do both; count stays DEPTH; ovf not set.
REQ-024 Push and pop together while empty: push only; set unf; count becomes 1; no same-cycle bypass to the outputs.
REQ-025 Push while full without pop: drop the word, leave storage unchanged, set ovf.
REQ-026 Pop while empty without push: no state change except setting unf.
REQ-027 I_sequencer and the IR_W source shall come combinationally from the head entry; the new head is visible in the cycle after a pop (latency 1 edge from push to visibility when empty).
REQ-028 The nEi gating shall be purely combinational and shall not affect queue state.
REQ-029 ovf and unf shall clear only on clr.

Reset
REQ-030 clr=1 shall immediately, without a clock, force count=0, head=tail=0, empty=1, full=0, ovf=0, unf=0, I_sequencer=NOP_OP.
REQ-031 Storage contents need not be cleared; no entry shall be observable after reset until it is pushed.
REQ-032 clr asserted mid-operation shall override all other inputs, including a concurrent push, pop or flush, on the same edge.
REQ-033 Deassertion of clr shall take effect at the next rising edge; an instruction pushed on that edge shall be accepted.

Verification
REQ-034 Reset, then push 0x1A, 0x2B with nEi=0 -> I_sequencer=1, IR_W=A, count=2; pop -> I_sequencer=2, IR_W=B, count=1.
REQ-035 Push 0x11, 0x22, 0x33, 0x44 -> full=1; push 0x55 -> ovf=1, count=4; four pops return opcodes 1,2,3,4, then empty=1 and I_sequencer=0.
REQ-036 Keep the queue at count=2 with simultaneous push/pop for 10 cycles (pointer wrap) -> FIFO order preserved, count stays 2, no flags set.
REQ-037 Empty queue, push 0x7C and pop on the same edge -> count=1, unf=1, I_sequencer=7 on the next cycle.
REQ-038 Count=3, nFlush=0 together with nLi=0 -> count=0, empty=1, pushed word discarded, flags unchanged.
REQ-039 nEi=1 -> IR_W=Z; asynchronous clr pulse between clock edges -> outputs reset immediately, before the next edge.
